ucaspian_tx_decoder: RTL and testbench

Host-side receiver for the byte stream that uCaspian transmits on write_data/write_vld/write_rdy. It parses variable-length response packets (output fire, time update, metric, ack) into single-cycle-wide event records. Events are delivered over a valid/ready handshake. Used in the on-FPGA self-test harness and the SoC host bridge, in place of the USB/UART host.

---
 rtl/ucaspian_pkt_pkg.sv | 46 ++++
 rtl/ucaspian_tx_decoder.sv | 152 +++++++++++++++
 tb/tb_ucaspian_tx_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ucaspian_pkt_pkg.sv
// Shared opcode and event definitions for the uCaspian TX byte stream.
// Used by both the host-side decoder and the matching encoder.
package ucaspian_pkt_pkg;

    localparam logic [7:0] OP_FIRE   = 8'h01;
    localparam logic [7:0] OP_TIME   = 8'h02;
    localparam logic [7:0] OP_METRIC = 8'h03;
    localparam logic [7:0] OP_ACK    = 8'h04;

    typedef enum logic [1:0] {
        EVT_FIRE   = 2'd0,
        EVT_TIME   = 2'd1,
        EVT_METRIC = 2'd2,
        EVT_ACK    = 2'd3
    } evt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    function automatic logic [2:0] op_len(input logic [7:0] op);
        case (op)
            OP_FIRE:   return 3'd1;
            OP_METRIC: return 3'd2;
            OP_TIME:   return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return (op == OP_FIRE) || (op == OP_TIME) ||
               (op == OP_METRIC) || (op == OP_ACK);
    endfunction

    function automatic evt_type_t op_type(input logic [7:0] op);
        case (op)
            OP_FIRE:   return EVT_FIRE;
            OP_TIME:   return EVT_TIME;
            OP_METRIC: return EVT_METRIC;
            default:   return EVT_ACK;
        endcase
    endfunction

endpackage

// File: rtl/ucaspian_tx_decoder.sv
// Parses the uCaspian TX byte stream into single event records
// delivered over a valid/ready handshake.
module ucaspian_tx_decoder
    import ucaspian_pkt_pkg::*;
#(
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        rx_rdy,
    output logic        evt_vld,
    input  logic        evt_rdy,
    output logic [1:0]  evt_type,
    output logic [7:0]  evt_addr,
    output logic [7:0]  evt_value,
    output logic [31:0] evt_time,
    output logic        err_unknown,
    output logic        err_timeout,
    output logic        busy
);

    localparam int GW = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TIMEOUT);

    state_t      state_q, state_d;
    evt_type_t   type_q, type_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  value_q, value_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] time_q, time_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [GW-1:0] gap_inc;
    logic        err_unknown_q, err_unknown_d;
    logic        err_timeout_q, err_timeout_d;
    logic        xfer;
    logic        emit;

    assign emit    = (state_q == ST_EMIT);
    assign rx_rdy  = !reset && !emit;
    assign xfer    = rx_vld && rx_rdy;
    assign gap_inc = gap_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        count_d       = count_q;
        addr_d        = addr_q;
        value_d       = value_q;
        shadow_d      = shadow_q;
        time_d        = time_q;
        gap_d         = gap_q;
        err_unknown_d = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gap_d = '0;
                if (xfer) begin
                    addr_d  = 8'h00;
                    value_d = 8'h00;
                    type_d  = op_type(rx_data);
                    count_d = op_len(rx_data);
                    if (rx_data == OP_ACK) begin
                        state_d = ST_EMIT;
                    end else if (op_known(rx_data)) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        err_unknown_d = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    gap_d   = '0;
                    count_d = count_q - 3'd1;
                    if (type_q == EVT_TIME) begin
                        shadow_d = {shadow_q[23:0], rx_data};
                    end
                    if (type_q == EVT_FIRE) begin
                        addr_d = rx_data;
                    end
                    if (type_q == EVT_METRIC) begin
                        if (count_q == 3'd2) addr_d = rx_data;
                        else value_d = rx_data;
                    end
                    if (count_q == 3'd1) begin
                        state_d = ST_EMIT;
                        if (type_q == EVT_TIME) begin
                            time_d = {shadow_q[23:0], rx_data};
                        end
                    end
                end else if (GAP_TIMEOUT > 0) begin
                    // A transfer in the same cycle takes priority over abort.
                    if (gap_inc == GAP_MAX) begin
                        gap_d         = '0;
                        err_timeout_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        gap_d = gap_inc;
                    end
                end
            end
            ST_EMIT: begin
                gap_d = '0;
                if (evt_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            type_q        <= EVT_FIRE;
            count_q       <= 3'd0;
            addr_q        <= 8'h00;
            value_q       <= 8'h00;
            shadow_q      <= 32'h0;
            time_q        <= 32'h0;
            gap_q         <= '0;
            err_unknown_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            count_q       <= count_d;
            addr_q        <= addr_d;
            value_q       <= value_d;
            shadow_q      <= shadow_d;
            time_q        <= time_d;
            gap_q         <= gap_d;
            err_unknown_q <= err_unknown_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign evt_vld     = emit;
    assign evt_type    = emit ? type_q : 2'b00;
    assign evt_addr    = emit ? addr_q : 8'h00;
    assign evt_value   = emit ? value_q : 8'h00;
    assign evt_time    = time_q;
    assign err_unknown = err_unknown_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ucaspian_tx_decoder.sv
// Scoreboard bench for the uCaspian TX decoder.
module tb_ucaspian_tx_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic        evt_vld;
    logic        evt_rdy;
    logic [1:0]  evt_type;
    logic [7:0]  evt_addr;
    logic [7:0]  evt_value;
    logic [31:0] evt_time;
    logic        err_unknown;
    logic        err_timeout;
    logic        busy;

    always #5 clk = ~clk;

    ucaspian_tx_decoder #(.GAP_TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_vld     (rx_vld),
        .rx_rdy     (rx_rdy),
        .evt_vld    (evt_vld),
        .evt_rdy    (evt_rdy),
        .evt_type   (evt_type),
        .evt_addr   (evt_addr),
        .evt_value  (evt_value),
        .evt_time   (evt_time),
        .err_unknown(err_unknown),
        .err_timeout(err_timeout),
        .busy       (busy)
    );

    typedef struct packed {
        logic [1:0]  t;
        logic [7:0]  a;
        logic [7:0]  v;
        logic [31:0] tm;
    } evt_t;

    evt_t exp_q[$];
    evt_t e;
    int n_chk  = 0;
    int n_fail = 0;
    int n_unk  = 0;
    int n_to   = 0;
    int n_evt  = 0;
    int n_push = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] t, input logic [7:0] a,
                        input logic [7:0] v, input logic [31:0] tm);
        exp_q.push_back({t, a, v, tm});
        n_push++;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data = b;
        rx_vld  = 1'b1;
        while (!rx_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("rx_rdy_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (err_unknown) n_unk++;
            if (err_timeout) n_to++;
            if (evt_vld && evt_rdy) begin
                n_evt++;
                if (exp_q.size() == 0) begin
                    check("evt_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_type", 32'(evt_type), 32'(e.t));
                    check("evt_addr", 32'(evt_addr), 32'(e.a));
                    check("evt_value", 32'(evt_value), 32'(e.v));
                    check("evt_time", evt_time, e.tm);
                end
            end
        end
    end

    int cnt;
    int u0;

    initial begin
        reset   = 1'b1;
        rx_vld  = 1'b0;
        rx_data = 8'h00;
        evt_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_rdy", 32'(rx_rdy), 32'd0);
        check("rst_evt_vld", 32'(evt_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_evt_time", evt_time, 32'd0);
        check("rst_evt_type", 32'(evt_type), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_rx_rdy", 32'(rx_rdy), 32'd1);

        // TIME then FIRE
        push(2'd1, 8'h00, 8'h00, 32'h12C);
        send(8'h02); send(8'h00); send(8'h00); send(8'h01); send(8'h2C);
        push(2'd0, 8'h17, 8'h00, 32'h12C);
        send(8'h01); send(8'h17);
        repeat (3) @(negedge clk);

        // METRIC held by back-pressure
        evt_rdy = 1'b0;
        push(2'd2, 8'h05, 8'hA0, 32'h12C);
        send(8'h03); send(8'h05); send(8'hA0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_vld", 32'(evt_vld), 32'd1);
            check("hold_type", 32'(evt_type), 32'd2);
            check("hold_addr", 32'(evt_addr), 32'h05);
            check("hold_value", 32'(evt_value), 32'hA0);
            check("hold_rx_rdy", 32'(rx_rdy), 32'd0);
        end
        @(posedge clk);
        #1;
        evt_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("after_hold_rx_rdy", 32'(rx_rdy), 32'd1);
        check("after_hold_vld", 32'(evt_vld), 32'd0);

        // ACK latency and back-to-back ACKs
        push(2'd3, 8'h00, 8'h00, 32'h12C);
        send(8'h04);
        @(negedge clk);
        check("ack_lat_vld", 32'(evt_vld), 32'd1);
        check("ack_lat_type", 32'(evt_type), 32'd3);
        repeat (2) @(negedge clk);
        push(2'd3, 8'h00, 8'h00, 32'h12C);
        push(2'd3, 8'h00, 8'h00, 32'h12C);
        send(8'h04); send(8'h04);
        repeat (3) @(negedge clk);

        // Unknown opcode dropped
        u0 = n_unk;
        send(8'h7F);
        repeat (3) @(negedge clk);
        check("unk_pulses", 32'(n_unk - u0), 32'd1);
        check("unk_busy", 32'(busy), 32'd0);
        push(2'd0, 8'h09, 8'h00, 32'h12C);
        send(8'h01); send(8'h09);
        repeat (3) @(negedge clk);

        // Gap timeout on a partial TIME packet
        send(8'h02); send(8'hAA);
        cnt = 0;
        @(negedge clk);
        while (!err_timeout && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("timeout_delay", 32'(cnt), 32'd8);
        repeat (2) @(negedge clk);
        check("timeout_pulses", 32'(n_to), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_time", evt_time, 32'h12C);
        push(2'd0, 8'h03, 8'h00, 32'h12C);
        send(8'h01); send(8'h03);
        repeat (3) @(negedge clk);

        // Reset mid-packet
        send(8'h02); send(8'h11); send(8'h22);
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rx_rdy", 32'(rx_rdy), 32'd0);
        check("arst_evt_vld", 32'(evt_vld), 32'd0);
        check("arst_evt_time", evt_time, 32'd0);
        check("arst_errs", 32'({err_unknown, err_timeout}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push(2'd3, 8'h00, 8'h00, 32'h0);
        send(8'h04);
        repeat (4) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("event_count", 32'(n_evt), 32'(n_push));
        check("unk_total", 32'(n_unk), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
